// File: rtl/pps_pulse_gen_if.sv
// Control/status bundle for pps_pulse_gen. The master side drives the channel
// configuration and strobes; the slave side (the generator) returns the pulse
// outputs, per-channel pulse counts and sync error flags.
interface pps_pulse_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int TICK_W = 32
);
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH-1:0]        sync_en;
  logic [NUM_CH*CNT_W-1:0]  div_i;
  logic [NUM_CH*CNT_W-1:0]  width_i;
  logic                     load;
  logic                     sync_in;
  logic                     tick_clr;
  logic [NUM_CH-1:0]        pulse_o;
  logic [NUM_CH*TICK_W-1:0] tick_cnt;
  logic [NUM_CH-1:0]        sync_err;

  modport master (
    output ch_en, sync_en, div_i, width_i, load, sync_in, tick_clr,
    input  pulse_o, tick_cnt, sync_err
  );

  modport slave (
    input  ch_en, sync_en, div_i, width_i, load, sync_in, tick_clr,
    output pulse_o, tick_cnt, sync_err
  );
endinterface

// File: rtl/pps_pulse_gen.sv
// Multi-channel programmable pulse generator. Each channel divides axi_aclk
// by a runtime divisor (down-counter reloaded on its terminal cycle) and emits
// a pulse of programmable width. New divisor/width values land in a shadow
// register and only take effect on a terminal cycle, so an in-flight period
// is never cut short. A rising edge on sync_in can force a terminal cycle on
// channels that allow it, re-aligning them to an external reference.
module pps_pulse_gen #(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 32,
  parameter int DEFAULT_DIV   = 100000,
  parameter int DEFAULT_WIDTH = 1,
  parameter int TICK_W        = 32
) (
  input  logic          axi_aclk,
  input  logic          axi_areset,
  pps_pulse_gen_if.slave bus
);

  localparam logic [CNT_W-1:0]  DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0]  WID_RST = CNT_W'(DEFAULT_WIDTH);
  localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TWO     = CNT_W'(2);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);

  logic sync_q;
  logic sync_edge;

  // Previous sync level for rising-edge detection, shared by all channels.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) sync_q <= 1'b0;
    else            sync_q <= bus.sync_in;
  end

  assign sync_edge = bus.sync_in & ~sync_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0]  cnt, div_act, wid_act, div_sh, wid_sh, wcnt;
    logic [CNT_W-1:0]  div_req, wid_req, div_san, wid_san, div_nx, wid_nx;
    logic [TICK_W-1:0] tick;
    logic              pending, pulse, err;
    logic              en, sync_hit, term;

    // Sanitise the requested values and pick the values the next terminal uses.
    always_comb begin
      div_req  = bus.div_i[k*CNT_W +: CNT_W];
      wid_req  = bus.width_i[k*CNT_W +: CNT_W];
      div_san  = (div_req < TWO) ? TWO : div_req;
      // Width is clipped so the output spends at least one cycle low per period.
      wid_san  = (wid_req >= div_san) ? (div_san - ONE) : wid_req;
      div_nx   = pending ? div_sh : div_act;
      wid_nx   = pending ? wid_sh : wid_act;
      en       = bus.ch_en[k];
      sync_hit = sync_edge & bus.sync_en[k] & en;
      term     = en & ((cnt == '0) | sync_hit);
    end

    // Period counter, pulse-width counter, shadow handover and pulse count.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
        cnt     <= DIV_RST - ONE;
        div_act <= DIV_RST;
        wid_act <= WID_RST;
        div_sh  <= DIV_RST;
        wid_sh  <= WID_RST;
        pending <= 1'b0;
        wcnt    <= '0;
        pulse   <= 1'b0;
        tick    <= '0;
        err     <= 1'b0;
      end else begin
        // A sync edge that coincides with the natural terminal is not an error.
        err <= sync_hit & (cnt != '0);
        if (!en) begin
          // Idle channel: hold ready to count a full period, apply shadows now.
          cnt     <= div_nx - ONE;
          div_act <= div_nx;
          wid_act <= wid_nx;
          pending <= 1'b0;
          pulse   <= 1'b0;
          wcnt    <= '0;
        end else if (term) begin
          cnt     <= div_nx - ONE;
          div_act <= div_nx;
          wid_act <= wid_nx;
          pending <= 1'b0;
          if (wid_nx != '0) begin
            pulse <= 1'b1;
            wcnt  <= wid_nx - ONE;
            tick  <= tick + TICK_ONE;
          end else begin
            pulse <= 1'b0;
          end
        end else begin
          cnt <= cnt - ONE;
          if (pulse && (wcnt != '0)) wcnt  <= wcnt - ONE;
          else                       pulse <= 1'b0;
        end
        // A load always re-arms the shadow, even on a terminal cycle, so the
        // new values wait for the following terminal.
        if (bus.load) begin
          div_sh  <= div_san;
          wid_sh  <= wid_san;
          pending <= 1'b1;
        end
        if (bus.tick_clr) tick <= '0;
      end
    end

    assign bus.pulse_o[k]                 = pulse;
    assign bus.sync_err[k]                = err;
    assign bus.tick_cnt[k*TICK_W +: TICK_W] = tick;
  end

endmodule

// File: tb/tb_pps_pulse_gen.sv
// Directed bench for pps_pulse_gen with DEFAULT_DIV = 10. Stimulus pushes the
// expected outputs after each clock edge into a scoreboard queue; a monitor on
// the falling edge pops and compares against the DUT.
module tb_pps_pulse_gen;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int TICK_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pps_pulse_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TICK_W(TICK_W)) bus ();

  pps_pulse_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(10),
    .DEFAULT_WIDTH(1), .TICK_W(TICK_W)
  ) dut (
    .axi_aclk  (clk),
    .axi_areset(rst),
    .bus       (bus)
  );

  typedef struct {
    string       tag;
    logic [3:0]  pulse;
    logic [3:0]  err;
    bit          tchk;
    logic [15:0] tick;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: compare whatever expectation is queued for this cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (bus.pulse_o !== e.pulse || bus.sync_err !== e.err ||
          (e.tchk && bus.tick_cnt[15:0] !== e.tick)) begin
        n_bad++;
        $display("FAIL %s @%0t: got pulse_o=%b sync_err=%b tick0=%0d, required pulse_o=%b sync_err=%b tick0=%0d%s",
                 e.tag, $time, bus.pulse_o, bus.sync_err, bus.tick_cnt[15:0],
                 e.pulse, e.err, e.tick, e.tchk ? "" : " (tick unchecked)");
      end
    end
  end

  task automatic push(string tag, logic [3:0] p, logic [3:0] er, bit tchk, logic [15:0] t);
    exp_t x;
    x.tag = tag; x.pulse = p; x.err = er; x.tchk = tchk; x.tick = t;
    sb.push_back(x);
  endtask

  task automatic step(string tag, logic [3:0] p, logic [3:0] er, bit tchk, logic [15:0] t);
    @(posedge clk);
    #1;
    push(tag, p, er, tchk, t);
  endtask

  task automatic set_all(int d, int w);
    bus.div_i   = {NUM_CH{16'(d)}};
    bus.width_i = {NUM_CH{16'(w)}};
  endtask

  function automatic bit hi(int k, int base, int per, int wid);
    return (k >= base) && (((k - base) % per) < wid);
  endfunction

  initial begin
    logic c0, c1, c2;
    bus.ch_en    = 4'hF;
    bus.sync_en  = 4'h0;
    bus.load     = 1'b0;
    bus.sync_in  = 1'b0;
    bus.tick_clr = 1'b0;
    set_all(0, 0);

    repeat (2) begin
      @(posedge clk); #1;
      push("reset_state", 4'h0, 4'h0, 1, 16'd0);
    end
    rst = 1'b0;

    // Defaults: first pulse 10 edges after release, then every 10.
    for (int k = 1; k <= 30; k++)
      step("defaults", {4{k % 10 == 0}}, 4'h0, 1, 16'(k / 10));

    // Load 5/3 mid-period; the running period still ends at edge 40.
    for (int k = 31; k <= 54; k++) begin
      c0 = (k < 40) ? 1'b0 : hi(k, 40, 5, 3);
      step("load_5_3", {4{c0}}, 4'h0, k == 54, 16'd6);
      if (k == 33) begin bus.load = 1'b1; set_all(5, 3); end
      if (k == 34) bus.load = 1'b0;
      if (k == 54) begin bus.load = 1'b1; set_all(1, 9); end
    end

    // Load coincides with terminal 55: old 5/3 used once, then div 2 width 1.
    for (int k = 55; k <= 70; k++) begin
      c0 = (k < 60) ? hi(k, 55, 5, 3) : (k % 2 == 0);
      step("sanitise_1_9", {4{c0}}, 4'h0, k == 70, 16'd13);
      if (k == 55) bus.load = 1'b0;
      if (k == 70) begin bus.load = 1'b1; set_all(4, 0); end
    end

    // Width 0: no pulses, count frozen.
    for (int k = 71; k <= 90; k++) begin
      step("width_zero", 4'h0, 4'h0, 1, 16'd13);
      if (k == 71) bus.load = 1'b0;
      if (k == 90) begin bus.load = 1'b1; set_all(10, 1); bus.sync_en = 4'b0001; end
    end

    // Sync off-phase (cnt=3) at edge 99, then on-phase (cnt=0) at edge 109.
    for (int k = 91; k <= 121; k++) begin
      c0 = (k == 92) || (k == 99) || (k == 109) || (k == 119);
      c1 = (k == 92) || (k == 102) || (k == 112);
      step("sync", {c1, c1, c1, c0}, {3'b000, k == 99}, k == 121, 16'd17);
      if (k == 91)  bus.load = 1'b0;
      if (k == 98)  bus.sync_in = 1'b1;
      if (k == 100) bus.sync_in = 1'b0;
      if (k == 108) bus.sync_in = 1'b1;
      if (k == 110) bus.sync_in = 1'b0;
      if (k == 121) begin bus.load = 1'b1; set_all(6, 3); end
    end

    // Channel 1 disabled mid-pulse and re-enabled; tick_clr on ch0 terminal 153.
    for (int k = 122; k <= 160; k++) begin
      c0 = hi(k, 129, 6, 3);
      c1 = (k == 122) || (k == 132) || (k == 133) || hi(k, 145, 6, 3);
      c2 = (k == 122) || hi(k, 132, 6, 3);
      step("isolate_clr", {c2, c2, c1, c0}, 4'h0, (k == 152) || (k == 153) || (k == 160),
           (k == 152) ? 16'd21 : (k == 153) ? 16'd0 : 16'd1);
      if (k == 122) bus.load = 1'b0;
      if (k == 133) bus.ch_en = 4'b1101;
      if (k == 139) bus.ch_en = 4'hF;
      if (k == 152) bus.tick_clr = 1'b1;
      if (k == 153) bus.tick_clr = 1'b0;
    end

    // Reset while ch0 is mid-pulse: outputs must clear before any clock edge.
    @(posedge clk); #1;
    rst = 1'b1;
    push("async_reset", 4'h0, 4'h0, 1, 16'd0);
    repeat (2) begin
      @(posedge clk); #1;
      push("held_reset", 4'h0, 4'h0, 1, 16'd0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 30; k++)
      step("after_reset", {4{k % 10 == 0}}, 4'h0, 1, 16'(k / 10));

    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
